// File: rtl/rv32m_share_arbiter_pkg.sv
// Shared definitions for the RV32M share arbiter: operand width, FSM states and grant decode.
`ifndef XLEN
`define XLEN 32
`endif

package arvi_rv32m_arb_pkg;

  localparam int N_REQ_DEFAULT = 2;
  localparam int N_REQ_MAX     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // One-hot decode of a grant index, sized for the largest supported hart count.
  function automatic logic [N_REQ_MAX-1:0] gnt_onehot(input logic [2:0] idx);
    gnt_onehot = {{(N_REQ_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rv32m_share_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request after `last`, wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);

  int pos_s;

  // Scan positions last+1 .. last+N; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = {W{1'b0}};
    pos_s = 0;
    for (int i = 1; i <= N; i++) begin
      pos_s = int'(last) + i;
      pos_s = (pos_s >= N) ? (pos_s - N) : pos_s;
      for (int j = 0; j < N; j++) begin
        if (!valid && (pos_s == j) && req[j]) begin
          valid = 1'b1;
          idx   = W'(j);
        end else begin
          valid = valid;
          idx   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/rv32m_share_arbiter.sv
// Round-robin arbiter sharing one external RV32M mul/div unit between N_REQ hart ex stages.
module rv32m_share_arbiter
  import arvi_rv32m_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*`XLEN-1:0] i_rs1,
  input  logic [N_REQ*`XLEN-1:0] i_rs2,
  input  logic [N_REQ*3-1:0]     i_f3,
  output logic [N_REQ-1:0]       o_ack,
  output logic [`XLEN-1:0]       o_res,
  output logic                   o_busy,
  output logic [GNT_W-1:0]       o_gnt,
  output logic                   o_en,
  output logic [`XLEN-1:0]       o_rs1,
  output logic [`XLEN-1:0]       o_rs2,
  output logic [2:0]             o_f3,
  input  logic                   i_ack,
  input  logic [`XLEN-1:0]       i_res
);

  arb_state_e       state_r, state_s;
  logic [GNT_W-1:0] last_r, last_s, gnt_s, pick_idx_s;
  logic             mask_r, mask_s, pick_valid_s;
  logic [N_REQ-1:0] eff_req_s, ack_s;
  logic [`XLEN-1:0] res_s, rs1_s, rs2_s;
  logic [2:0]       f3_s;

  // The hart acked last is hidden for one IDLE cycle so its stale req is not re-issued.
  always_comb begin
    eff_req_s = i_req;
    if (mask_r) begin
      eff_req_s[last_r] = 1'b0;
    end else begin
      eff_req_s = i_req;
    end
  end

  rr_pick #(.N(N_REQ), .W(GNT_W)) u_rr_pick (
    .req   (eff_req_s),
    .last  (last_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output computation for the grant/issue/wait/respond sequence.
  always_comb begin
    state_s = state_r;
    gnt_s   = o_gnt;
    rs1_s   = o_rs1;
    rs2_s   = o_rs2;
    f3_s    = o_f3;
    res_s   = o_res;
    last_s  = last_r;
    mask_s  = mask_r;
    case (state_r)
      ST_IDLE: begin
        mask_s = 1'b0;
        if (pick_valid_s) begin
          gnt_s   = pick_idx_s;
          rs1_s   = i_rs1[int'(pick_idx_s)*`XLEN +: `XLEN];
          rs2_s   = i_rs2[int'(pick_idx_s)*`XLEN +: `XLEN];
          f3_s    = i_f3[int'(pick_idx_s)*3 +: 3];
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (i_ack) begin
          res_s   = i_res;
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        last_s  = o_gnt;
        mask_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
    ack_s = (state_s == ST_RESP) ? N_REQ'(gnt_onehot(3'(o_gnt))) : {N_REQ{1'b0}};
  end

  // State and output registers; strobes are derived from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      o_en    <= 1'b0;
      o_ack   <= {N_REQ{1'b0}};
      o_busy  <= 1'b0;
      o_res   <= {`XLEN{1'b0}};
      o_rs1   <= {`XLEN{1'b0}};
      o_rs2   <= {`XLEN{1'b0}};
      o_f3    <= 3'd0;
      o_gnt   <= {GNT_W{1'b0}};
      last_r  <= GNT_W'(N_REQ - 1);
      mask_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      o_en    <= (state_s == ST_ISSUE);
      o_ack   <= ack_s;
      o_busy  <= (state_s != ST_IDLE);
      o_res   <= res_s;
      o_rs1   <= rs1_s;
      o_rs2   <= rs2_s;
      o_f3    <= f3_s;
      o_gnt   <= gnt_s;
      last_r  <= last_s;
      mask_r  <= mask_s;
    end
  end

endmodule

// File: tb/tb_rv32m_share_arbiter.sv
// Scoreboard bench for rv32m_share_arbiter: the bench plays both harts and the M unit.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rv32m_share_arbiter;

  localparam int N = 2;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [N-1:0]     i_req = {N{1'b0}};
  logic [N*32-1:0]  i_rs1 = {(N*32){1'b0}};
  logic [N*32-1:0]  i_rs2 = {(N*32){1'b0}};
  logic [N*3-1:0]   i_f3  = {(N*3){1'b0}};
  logic             i_ack = 1'b0;
  logic [31:0]      i_res = 32'h0;
  logic [N-1:0]     o_ack;
  logic [31:0]      o_res;
  logic             o_busy;
  logic             o_gnt;
  logic             o_en;
  logic [31:0]      o_rs1;
  logic [31:0]      o_rs2;
  logic [2:0]       o_f3;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [31:0]  res;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  rv32m_share_arbiter #(.N_REQ(N)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_rs1  (i_rs1),
    .i_rs2  (i_rs2),
    .i_f3   (i_f3),
    .o_ack  (o_ack),
    .o_res  (o_res),
    .o_busy (o_busy),
    .o_gnt  (o_gnt),
    .o_en   (o_en),
    .o_rs1  (o_rs1),
    .o_rs2  (o_rs2),
    .o_f3   (o_f3),
    .i_ack  (i_ack),
    .i_res  (i_res)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expected response.
  always @(negedge i_clk) begin
    if (mon_en && (o_ack !== {N{1'b0}})) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got o_ack=%b res=0x%0h, expected no ack", o_ack, o_res);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_ack", 32'(o_ack), 32'(mon_e.ack));
        check("mon_res", o_res, mon_e.res);
      end
    end
  end

  task automatic set_ops(input int h, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] f3);
    i_rs1[h*32 +: 32] = rs1;
    i_rs2[h*32 +: 32] = rs2;
    i_f3[h*3 +: 3]    = f3;
  endtask

  task automatic expect_ack(input int h, input logic [31:0] res);
    exp_t e;
    e.ack    = {N{1'b0}};
    e.ack[h] = 1'b1;
    e.res    = res;
    exp_q.push_back(e);
  endtask

  task automatic wait_en(input int h, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] f3, output int lat);
    lat = 0;
    while ((o_en !== 1'b1) && (lat < 20)) begin
      @(negedge i_clk);
      lat++;
    end
    check("en_seen", 32'(o_en), 32'd1);
    check("gnt", 32'(o_gnt), 32'(h));
    check("op_rs1", o_rs1, rs1);
    check("op_rs2", o_rs2, rs2);
    check("op_f3", 32'(o_f3), 32'(f3));
    check("busy_issue", 32'(o_busy), 32'd1);
  endtask

  task automatic unit_ack(input int dly, input logic [31:0] res);
    repeat (dly) @(negedge i_clk);
    i_ack = 1'b1;
    i_res = res;
    @(negedge i_clk);
    i_ack = 1'b0;
    i_res = 32'h0;
    check("ack_seen", 32'(o_ack != {N{1'b0}}), 32'd1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = {N{1'b0}};
    i_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    do_reset();
    mon_en = 1'b1;
    check("rst_en", 32'(o_en), 32'd0);
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_res", o_res, 32'd0);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_rs1", o_rs1, 32'd0);
    check("rst_rs2", o_rs2, 32'd0);
    check("rst_f3", 32'(o_f3), 32'd0);

    // Single request from hart 0.
    set_ops(0, 32'd7, 32'd6, 3'd0);
    expect_ack(0, 32'd42);
    i_req = 2'b01;
    wait_en(0, 32'd7, 32'd6, 3'd0, lat);
    check("t1_latency", 32'(lat), 32'd1);
    @(negedge i_clk);
    check("t1_en_pulse", 32'(o_en), 32'd0);
    unit_ack(2, 32'd42);
    i_req = 2'b00;
    @(negedge i_clk);
    check("t1_busy_low", 32'(o_busy), 32'd0);
    check("t1_ack_pulse", 32'(o_ack), 32'd0);
    check("t1_res_held", o_res, 32'd42);

    // Contention right after reset, then again with last pointing at hart 1.
    do_reset();
    set_ops(0, 32'd1, 32'd2, 3'd4);
    set_ops(1, 32'd3, 32'd4, 3'd5);
    expect_ack(0, 32'd100);
    expect_ack(1, 32'd200);
    i_req = 2'b11;
    wait_en(0, 32'd1, 32'd2, 3'd4, lat);
    unit_ack(1, 32'd100);
    i_req[0] = 1'b0;
    wait_en(1, 32'd3, 32'd4, 3'd5, lat);
    check("t2_b2b_lat", 32'(lat), 32'd2);
    unit_ack(1, 32'd200);
    set_ops(0, 32'd10, 32'd20, 3'd1);
    set_ops(1, 32'd30, 32'd40, 3'd2);
    expect_ack(0, 32'd300);
    expect_ack(1, 32'd400);
    i_req = 2'b11;
    wait_en(0, 32'd10, 32'd20, 3'd1, lat);
    unit_ack(1, 32'd300);
    i_req[0] = 1'b0;
    wait_en(1, 32'd30, 32'd40, 3'd2, lat);
    unit_ack(1, 32'd400);
    i_req = 2'b00;

    // Spurious acks in IDLE and in ISSUE are ignored.
    @(negedge i_clk);
    i_ack = 1'b1;
    i_res = 32'h1234;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("t4_idle_ack_ignored", 32'(o_ack), 32'd0);
    check("t4_idle_busy", 32'(o_busy), 32'd0);
    set_ops(1, 32'h11, 32'h22, 3'd7);
    expect_ack(1, 32'hFFFF_FFFF);
    i_req = 2'b10;
    wait_en(1, 32'h11, 32'h22, 3'd7, lat);
    i_ack = 1'b1;
    i_res = 32'hDEAD;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("t4_issue_ack_ignored", 32'(o_ack), 32'd0);
    check("t4_busy_wait", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    check("t4_still_waiting", 32'(o_ack), 32'd0);
    unit_ack(0, 32'hFFFF_FFFF);
    i_req = 2'b00;
    @(negedge i_clk);
    check("t4_res_held", o_res, 32'hFFFF_FFFF);

    // Re-grant mask: hart 0 keeps requesting after its ack.
    set_ops(0, 32'd5, 32'd5, 3'd6);
    expect_ack(0, 32'd77);
    expect_ack(0, 32'd88);
    i_req = 2'b01;
    wait_en(0, 32'd5, 32'd5, 3'd6, lat);
    unit_ack(1, 32'd77);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t3_mask_no_en", 32'(o_en), 32'd0);
    check("t3_mask_idle", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    check("t3_regrant_en", 32'(o_en), 32'd1);
    wait_en(0, 32'd5, 32'd5, 3'd6, lat);
    unit_ack(1, 32'd88);
    i_req = 2'b00;

    // Reset while waiting on hart 1; a late unit ack must be dropped.
    set_ops(1, 32'd9, 32'd9, 3'd0);
    i_req = 2'b10;
    wait_en(1, 32'd9, 32'd9, 3'd0, lat);
    @(negedge i_clk);
    check("t5_busy_wait", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    i_req = 2'b00;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_ack = 1'b1;
    i_res = 32'd5;
    @(negedge i_clk);
    i_ack = 1'b0;
    check("t5_no_ack", 32'(o_ack), 32'd0);
    check("t5_res_zero", o_res, 32'd0);
    check("t5_idle", 32'(o_busy), 32'd0);
    check("t5_gnt_zero", 32'(o_gnt), 32'd0);
    check("t5_rs1_zero", o_rs1, 32'd0);
    check("t5_en_low", 32'(o_en), 32'd0);
    set_ops(0, 32'hA, 32'hB, 3'd3);
    set_ops(1, 32'hC, 32'hD, 3'd2);
    expect_ack(0, 32'd500);
    i_req = 2'b11;
    wait_en(0, 32'hA, 32'hB, 3'd3, lat);
    unit_ack(1, 32'd500);
    i_req[0] = 1'b0;

    // Hart 1 drops its request mid-operation; hart 0 queues behind it.
    expect_ack(1, 32'h600);
    wait_en(1, 32'hC, 32'hD, 3'd2, lat);
    @(negedge i_clk);
    i_req[1] = 1'b0;
    set_ops(1, 32'h0, 32'h0, 3'd0);
    set_ops(0, 32'hE, 32'hF, 3'd1);
    expect_ack(0, 32'h700);
    i_req[0] = 1'b1;
    @(negedge i_clk);
    check("t6_ops_stable", o_rs1, 32'hC);
    unit_ack(0, 32'h600);
    wait_en(0, 32'hE, 32'hF, 3'd1, lat);
    unit_ack(1, 32'h700);
    i_req = 2'b00;

    repeat (3) @(negedge i_clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
